// File: rtl/ro_edge_counter.sv
// Ring-oscillator measurement back-end: counts synchronised rising edges of ro_in
// over a 2^(8+win_sel)-cycle gate window and exposes a saturating, byte-selectable result.
module ro_edge_counter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ro_in,
    input  logic       start,
    input  logic [2:0] win_sel,
    input  logic       byte_sel,
    output logic [7:0] result_byte,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                 sync_prev_reg;
    logic                 start_d_reg;
    logic [2:0]           win_reg, win_next;
    logic [15:0]          tmr_reg, tmr_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 flag_reg, flag_next;
    logic [CNT_W-1:0]     result_reg, result_next;
    logic                 ovf_reg, ovf_next;
    logic                 done_reg, done_next;
    logic                 busy_reg, busy_next;

    logic                 ro_rise;
    logic                 start_rise;
    logic [15:0]          win_last;
    logic [15:0]          result_ext;

    assign ro_rise    = sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
    assign start_rise = start & ~start_d_reg;
    // Last timer value of the window: 2^(8+win) - 1.
    assign win_last   = 16'h7FFF >> (3'd7 - win_reg);

    // Input conditioning: synchroniser chain, edge-detect flop and start edge flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg      <= '0;
            sync_prev_reg <= 1'b0;
            start_d_reg   <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], ro_in};
            sync_prev_reg <= sync_reg[SYNC_STAGES-1];
            start_d_reg   <= start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            win_reg    <= '0;
            tmr_reg    <= '0;
            cnt_reg    <= '0;
            flag_reg   <= 1'b0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            win_reg    <= win_next;
            tmr_reg    <= tmr_next;
            cnt_reg    <= cnt_next;
            flag_reg   <= flag_next;
            result_reg <= result_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        win_next    = win_reg;
        tmr_next    = tmr_reg;
        cnt_next    = cnt_reg;
        flag_next   = flag_reg;
        result_next = result_reg;
        ovf_next    = ovf_reg;
        done_next   = done_reg;
        busy_next   = busy_reg;
        case (state_reg)
            IDLE: begin
                if (start_rise) begin
                    state_next = ARM;
                    win_next   = win_sel;
                    tmr_next   = 16'(SYNC_STAGES);
                    cnt_next   = '0;
                    flag_next  = 1'b0;
                    done_next  = 1'b0;
                    ovf_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            ARM: begin
                // Lets edges captured before the start flush out of the synchroniser.
                if (tmr_reg == 16'd0) begin
                    state_next = COUNT;
                    tmr_next   = win_last;
                end else begin
                    tmr_next = tmr_reg - 16'd1;
                end
            end
            COUNT: begin
                if (ro_rise) begin
                    if (cnt_reg == CNT_MAX) flag_next = 1'b1;
                    else                    cnt_next  = cnt_reg + CNT_W'(1);
                end
                if (tmr_reg == 16'd0) begin
                    state_next  = IDLE;
                    result_next = cnt_next;
                    ovf_next    = flag_next;
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                end else begin
                    tmr_next = tmr_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Zero-extend the result to 16 bits so the upper byte reads 0 above CNT_W.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ext
            if (gi < CNT_W) begin : g_bit
                assign result_ext[gi] = result_reg[gi];
            end else begin : g_zero
                assign result_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign result_byte = byte_sel ? result_ext[15:8] : result_ext[7:0];
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign ovf         = ovf_reg;

endmodule

// File: tb/tb_ro_edge_counter.sv
// Scoreboard bench for ro_edge_counter: a default instance and a CNT_W=12 instance
// share stimulus; expected results are queued at start and compared at done.
module tb_ro_edge_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ro_in;
    logic       start;
    logic [2:0] win_sel;
    logic       byte_sel;
    logic [7:0] rb, rb12;
    logic       busy, done, ovf;
    logic       busy12, done12, ovf12;

    int n_vec  = 0;
    int n_miss = 0;
    int ro_per = 0;
    int ro_ph  = 0;
    int held_word = 0;

    typedef struct {
        int cnt;
        int ovf;
        int cnt12;
        int ovf12;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ro_edge_counter dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .win_sel(win_sel),
        .byte_sel(byte_sel), .result_byte(rb), .busy(busy), .done(done), .ovf(ovf)
    );

    ro_edge_counter #(.CNT_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .win_sel(win_sel),
        .byte_sel(byte_sel), .result_byte(rb12), .busy(busy12), .done(done12), .ovf(ovf12)
    );

    // Oscillator stand-in: period ro_per clk cycles, 0 means stuck low.
    always @(negedge clk) begin
        if (ro_per == 0) begin
            ro_in = 1'b0;
        end else begin
            ro_ph = (ro_ph + 1) % ro_per;
            ro_in = (ro_ph < ro_per / 2);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // A periodic signal whose period divides the window yields exactly N/period rises.
    task automatic push_exp(input int w, input int p);
        exp_t e;
        int c;
        c = (p == 0) ? 0 : (256 << w) / p;
        e.cnt   = c;
        e.ovf   = 0;
        e.cnt12 = (c > 4095) ? 4095 : c;
        e.ovf12 = (c > 4095) ? 1 : 0;
        sb.push_back(e);
    endtask

    // Called at a negedge with start already high; the next posedge is E0.
    task automatic wait_done(input string tag, input int w, input bit hold, input bit poke);
        int   n;
        int   cyc;
        int   busy_n;
        exp_t e;
        logic [7:0] lo, hi;
        n = 256 << w;
        busy_n = 0;
        for (cyc = 0; cyc <= n + 20; cyc++) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (cyc == 0) begin
                check({tag, "_busy0"}, busy, 1);
                check({tag, "_done0"}, done, 0);
            end
            if (cyc == 1 && !hold) start = 1'b0;
            if (cyc == 8)
                check({tag, "_hold"}, rb, byte_sel ? (held_word >> 8) & 255 : held_word & 255);
            if (poke && cyc == n / 2)     start = 1'b1;
            if (poke && cyc == n / 2 + 2) start = 1'b0;
            if (done) break;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, cyc, n + 3);
        check({tag, "_busycyc"}, busy_n, n + 3);
        check({tag, "_done12"}, done12, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            byte_sel = 1'b0;
            #1;
            lo = rb;
            check({tag, "_lo"}, rb, e.cnt & 255);
            check({tag, "_lo12"}, rb12, e.cnt12 & 255);
            byte_sel = 1'b1;
            #1;
            hi = rb;
            check({tag, "_hi"}, rb, (e.cnt >> 8) & 255);
            check({tag, "_hi12"}, rb12, (e.cnt12 >> 8) & 255);
            check({tag, "_ovf"}, ovf, e.ovf);
            check({tag, "_ovf12"}, ovf12, e.ovf12);
            held_word = e.cnt;
            $display("meas %s: win=%0d lat=%0d result=0x%02h%02h ovf=%0d res12_hi=0x%02h ovf12=%0d",
                     tag, w, cyc, hi, lo, ovf, rb12, ovf12);
        end
    endtask

    task automatic measure(input string tag, input int w, input int p, input bit hold, input bit poke);
        @(negedge clk);
        push_exp(w, p);
        win_sel = 3'(w);
        start   = 1'b1;
        wait_done(tag, w, hold, poke);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_rb"}, rb, 0);
        check({tag, "_ovf12"}, ovf12, 0);
        check({tag, "_rb12"}, rb12, 0);
        $display("reset %s: busy=%0d done=%0d ovf=%0d rb=0x%02h", tag, busy, done, ovf, rb);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        win_sel  = 3'd0;
        byte_sel = 1'b0;
        ro_per   = 8;
        #23;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        measure("basic", 0, 8, 1'b0, 1'b0);
        measure("poke", 0, 8, 1'b0, 1'b1);

        ro_per = 2;
        repeat (10) @(negedge clk);
        measure("long", 7, 2, 1'b0, 1'b0);

        ro_per = 0;
        repeat (10) @(negedge clk);
        measure("stuck", 0, 0, 1'b0, 1'b0);

        ro_per = 8;
        repeat (10) @(negedge clk);
        measure("heldstart", 0, 8, 1'b1, 1'b0);
        repeat (300) @(negedge clk);
        check("heldstart_idle_busy", busy, 0);
        check("heldstart_idle_done", done, 1);
        start = 1'b0;
        repeat (5) @(negedge clk);

        // Abort a win_sel=2 measurement mid-COUNT with an asynchronous reset.
        byte_sel = 1'b0;
        win_sel  = 3'd2;
        start    = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        check("midcount_busy", busy, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        held_word = 0;
        repeat (1100) @(negedge clk);
        check("post_abort_done", done, 0);
        check("post_abort_busy", busy, 0);
        measure("after_abort", 2, 8, 1'b0, 1'b0);

        // start held high through reset release is taken as a rising edge.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        held_word = 0;
        push_exp(0, 8);
        win_sel = 3'd0;
        rst_n   = 1'b1;
        wait_done("rel_start", 0, 1'b0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ro_edge_counter.md
# ro_edge_counter

Measurement back-end for the ring-oscillator tile. It consumes the (pre-divided) oscillator output, counts its rising edges over a programmable gate window of system-clock cycles, and presents the saturating result as a byte-selectable value on the tile's dedicated outputs. Control comes from the dedicated inputs: a start request, a window select and a byte select.

## Interface
Parameters:
- CNT_W, 16, width of the edge counter and result register (range 8..16).
- SYNC_STAGES, 2, flip-flop stages synchronising `ro_in` into `clk` (minimum 2).

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low; asserting it clears all state immediately.
- ro_in  in  1  divided oscillator signal, asynchronous to `clk`. Its frequency must stay below clk/2.
- start  in  1  measurement request. A rising edge is detected in the `clk` domain.
- win_sel  in  3  window select. Window N = 2^(8+win_sel) cycles (256..32768). Sampled on accepted start.
- byte_sel  in  1  output select: 0 = result[7:0]; 1 = result[15:8], with bits at or above CNT_W read as 0.
- result_byte  out  8  selected byte of the latched result (combinational mux of registers).
- busy  out  1  measurement in progress.
- done  out  1  result valid. High from completion until the next accepted start.
- ovf  out  1  counter saturated during the last completed window.

## Operation
- Input conditioning:
  - `ro_in` passes through a SYNC_STAGES flop chain, then an edge-detect flop.
  - `ro_rise` = sync_out & ~sync_prev.
  - `start` is registered once: `start_rise` = start & ~start_d.
- FSM states: IDLE, ARM, COUNT.
  - IDLE:
    - `start_rise` → ARM.
    - Same edge: latch `win_sel`; clear `cnt`; clear `done` and `ovf`; set `busy`.
  - ARM:
    - Lasts exactly SYNC_STAGES+1 cycles, flushing stale synchroniser/edge-detector state.
    - No counting; then → COUNT.
  - COUNT:
    - Lasts exactly N cycles. `cnt` increments on every cycle with `ro_rise`=1.
    - Arithmetic: unsigned, saturating at 2^CNT_W−1. An increment attempted at saturation sets the internal ovf flag and leaves `cnt` unchanged.
    - On the last COUNT cycle's edge:
      - result ← cnt plus that cycle's increment;
      - `ovf` ← flag;
      - `done` ← 1, `busy` ← 0;
      - → IDLE.
- `start_rise` in ARM or COUNT is ignored: no restart, no queuing.
- `start_rise` in IDLE while `done`=1 starts a new measurement. `result_byte` keeps the old value until the new completion overwrites it.
- `byte_sel` may change at any time. `result_byte` follows combinationally.
- Reset values:
  - result 0, result_byte 0x00;
  - busy 0, done 0, ovf 0;
  - FSM IDLE;
  - all synchroniser, edge and start flops 0.
- Reset asserted mid-measurement aborts it; no partial result is latched. After release, the block waits in IDLE for a fresh `start` rising edge. A `start` already held high at release counts as a rising edge one cycle later, because start_d resets to 0.

## Timing
- Edge E0 samples `start_rise`=1 in IDLE → after E0: busy=1, FSM=ARM.
- ARM occupies cycles E1..E(SYNC_STAGES+1). COUNT occupies the next N cycles.
- `done`=1 and `busy`=0 are visible after edge E0+SYNC_STAGES+1+N. With defaults: start-to-done = N+3 cycles.
- Counted edges are those whose `ro_rise` is high during COUNT. `ro_in` latency to `ro_rise` is SYNC_STAGES+1 cycles.
- Counting accuracy is ±1 edge versus the true edge count in the window, due to the synchroniser phase.
- `ro_in` held constant for the whole window → result 0, ovf 0.
- Throughput: a new start is accepted on the first IDLE cycle after completion. Minimum period between starts is N+4 cycles.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-COUNT (win_sel=2).
  - Response: busy, done, ovf = 0 and result_byte = 0x00 immediately. No done until a new start rising edge; that next measurement completes normally.
- Basic count:
  - Stimulus: win_sel=0, ro_in period 8 clk, start pulse.
  - Response: done after 259 cycles; result in 31..33 (nominal 32); ovf=0; busy high for exactly 259 cycles.
- Long window and byte select:
  - Stimulus: win_sel=7, ro_in period 2 clk.
  - Response: result 16384±1. byte_sel=0 → 0x00 or 0xFF/0x01 per exact value; byte_sel=1 → 0x40 (or 0x3F).
- Saturation:
  - Stimulus: CNT_W=12, win_sel=7, ro_in period 2 clk.
  - Response: result 4095 (byte 0xFF / 0x0F); ovf=1.
- Ignored / re-start:
  - Stimulus: second start rising edge during COUNT.
  - Response: no effect; done time unchanged.
  - Stimulus: start after done with ro_in stuck low.
  - Response: done drops on the accepting edge; old result held until completion; then result=0, ovf=0.
- Start edge semantics:
  - Stimulus: start held high across multiple measurements.
  - Response: exactly one measurement.
  - Stimulus: start high at reset release.
  - Response: measurement begins one cycle after release.
